trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/oscilo_pkg.sv | 26 ++
 rtl/capture_ram.sv | 29 ++
 rtl/trigger_capture.sv | 150 +++++++++++++++
 tb/tb_trigger_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oscilo_pkg.sv
// Shared types and constants for the oscilloscope capture path.
package oscilo_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_e;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

  // Level crossing between two consecutive valid samples.
  function automatic logic edge_hit(input logic       falling,
                                    input logic [7:0] prev,
                                    input logic [7:0] cur,
                                    input logic [7:0] level);
    if (falling == TRIG_FALLING)
      return (prev > level) && (cur <= level);
    else
      return (prev < level) && (cur >= level);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: one synchronous write port, one registered read port.
module capture_ram #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trigger_capture.sv
// Edge-triggered sample capture with programmable pre-trigger depth.
module trigger_capture
  import oscilo_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    sample_in,
  input  logic          sample_valid,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [7:0]    trig_level,
  input  logic          trig_falling,
  input  logic [AW-1:0] pretrig,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  cap_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic          force_pend_q, force_pend_d;

  logic          wr_en;
  logic          hit;
  logic [AW:0]   pre_len;
  logic [AW:0]   post_len;
  logic [AW:0]   cnt_inc;
  logic [AW-1:0] rd_phys;

  assign pre_len  = {1'b0, pretrig};
  assign post_len = DEPTH_V - pre_len;
  assign cnt_inc  = cnt_q + 1'b1;
  // A forced trigger lands on the current valid sample or the next one.
  assign hit      = force_trig || force_pend_q ||
                    (prev_vld_q && edge_hit(trig_falling, prev_q, sample_in, trig_level));

  // Next-state, pointer and counter logic; arm overrides everything else.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    trig_addr_d  = trig_addr_q;
    force_pend_d = force_pend_q;
    wr_en        = 1'b0;

    if (arm) begin
      state_d      = (pretrig == '0) ? ARMED : PRE;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      prev_vld_d   = 1'b0;
      force_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        PRE: begin
          if (sample_valid) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prev_d     = sample_in;
            prev_vld_d = 1'b1;
            if (cnt_inc == pre_len) begin
              cnt_d   = '0;
              state_d = ARMED;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ARMED: begin
          if (sample_valid) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prev_d     = sample_in;
            prev_vld_d = 1'b1;
            if (hit) begin
              trig_addr_d  = wr_ptr_q;
              force_pend_d = 1'b0;
              cnt_d        = (AW+1)'(1);
              state_d      = (post_len == (AW+1)'(1)) ? DONE : POST;
            end
          end else if (force_trig) begin
            force_pend_d = 1'b1;
          end
        end
        POST: begin
          if (sample_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == post_len) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      prev_vld_q   <= 1'b0;
      trig_addr_q  <= '0;
      force_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      prev_vld_q   <= prev_vld_d;
      trig_addr_q  <= trig_addr_d;
      force_pend_q <= force_pend_d;
    end
  end

  // Previous-sample data register; qualified by prev_vld_q.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  // Logical index 0 is the oldest sample of the capture window.
  assign rd_phys = trig_addr_q - pretrig + rd_addr;

  capture_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en & ~rst),
    .waddr (wr_ptr_q),
    .wdata (sample_in),
    .raddr (rd_phys),
    .rdata (rd_data)
  );

  assign busy      = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
  assign done      = (state_q == DONE);
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture.
module tb_trigger_capture;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          arm = 1'b0;
  logic          force_trig = 1'b0;
  logic [7:0]    trig_level = '0;
  logic          trig_falling = 1'b0;
  logic [AW-1:0] pretrig = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;

  always #5 clk = ~clk;

  trigger_capture #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .force_trig   (force_trig),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .pretrig      (pretrig),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .trig_addr    (trig_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the list of valid samples accepted since arm,
  // the index of the trigger sample within that list, and the config.
  int m_stream[$];
  int m_t     = -1;
  bit m_cap   = 0;
  bit m_pend  = 0;
  int m_pre   = 0;
  int m_lvl   = 0;
  bit m_fall  = 0;
  int m_taddr = 0;
  int ramp    = 0;

  function automatic bit m_done();
    return (m_t >= 0) && (m_stream.size() >= m_t + (DEPTH - m_pre));
  endfunction

  function automatic bit m_edge(input int p, input int c);
    if (m_fall) return (p > m_lvl) && (c <= m_lvl);
    else        return (p < m_lvl) && (c >= m_lvl);
  endfunction

  task automatic configure(input int pre, input int lvl, input bit fall);
    pretrig = pre[AW-1:0]; trig_level = lvl[7:0]; trig_falling = fall;
    m_pre = pre; m_lvl = lvl; m_fall = fall;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, m_cap && !m_done()});
    check({tag, "_done"}, {31'b0, done}, {31'b0, m_cap && m_done()});
    check({tag, "_trig_addr"}, {24'b0, trig_addr}, m_taddr);
  endtask

  // One clock: drive at negedge, update model, check at next negedge.
  task automatic step(input bit v, input int d, input bit a, input bit f);
    int k;
    bit armed;
    sample_valid = v; sample_in = d[7:0]; arm = a; force_trig = f;
    if (a) begin
      m_stream.delete(); m_t = -1; m_cap = 1; m_pend = 0;
    end else if (m_cap && !m_done()) begin
      armed = (m_stream.size() >= m_pre) && (m_t < 0);
      if (v) begin
        k = m_stream.size();
        m_stream.push_back(d);
        if (armed && (m_pend || f || (k >= 1 && m_edge(m_stream[k-1], d)))) begin
          m_t = k; m_pend = 0; m_taddr = k % DEPTH;
        end
      end else if (armed && f) begin
        m_pend = 1;
      end
    end
    @(negedge clk);
    sample_valid = 0; arm = 0; force_trig = 0;
    check_status("cyc");
  endtask

  task automatic do_rst(input bit with_arm);
    rst = 1; arm = with_arm;
    m_cap = 0; m_t = -1; m_pend = 0; m_taddr = 0; m_stream.delete();
    @(negedge clk);
    rst = 0; arm = 0;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_trig_addr", {24'b0, trig_addr}, 0);
  endtask

  // dmode 0 = ramp 0..254 (advances on valid only), 1 = random with rare force.
  // vmode 0 = always valid, 1 = toggling, 2 = random.
  task automatic run(input int dmode, input int vmode, input int stop_size,
                     input int stop_post, input int max_cyc);
    int  cyc = 0;
    bit  v;
    bit  f;
    int  d;
    while (1) begin
      if (m_done()) break;
      if (stop_size >= 0 && m_stream.size() == stop_size) break;
      if (stop_post >= 0 && m_t >= 0 && m_stream.size() - m_t >= stop_post) break;
      if (cyc >= max_cyc) begin
        check("run_timeout", 0, 1);
        break;
      end
      case (vmode)
        0:       v = 1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 9) < 7;
      endcase
      f = 0;
      if (dmode == 0) begin
        d = ramp;
        if (v) ramp = (ramp == 254) ? 0 : ramp + 1;
      end else begin
        d = $urandom_range(0, 255);
        f = $urandom_range(0, 299) == 0;
      end
      step(v, d, 0, f);
      cyc++;
    end
  endtask

  task automatic read_idx(input int idx);
    rd_addr = idx[AW-1:0];
    @(negedge clk);
  endtask

  task automatic compare_buffer(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      read_idx(i);
      check({tag, "_buf"}, {24'b0, rd_data}, m_stream[m_t - m_pre + i]);
    end
  endtask

  typedef struct {
    int idx;
    int exp;
  } rd_vec_t;

  rd_vec_t vt[5];

  task automatic table_reads(input string tag);
    for (int i = 0; i < 5; i++) begin
      read_idx(vt[i].idx);
      check({tag, "_tbl"}, {24'b0, rd_data}, vt[i].exp);
    end
  endtask

  initial begin
    int forced;
    vt[0] = '{idx: 0,   exp: 112};
    vt[1] = '{idx: 16,  exp: 128};
    vt[2] = '{idx: 142, exp: 254};
    vt[3] = '{idx: 143, exp: 0};
    vt[4] = '{idx: 255, exp: 112};

    // Reset state
    repeat (2) @(negedge clk);
    do_rst(0);

    // Ramp, rising at 128, pretrig 16
    configure(16, 128, 0);
    ramp = 0;
    step(0, 0, 1, 0);
    run(0, 0, -1, -1, 2000);
    check("ramp_done", {31'b0, done}, 1);
    check("ramp_trig_addr", {24'b0, trig_addr}, 128);
    table_reads("ramp");
    compare_buffer("ramp");

    // Falling at 10: only the 254 -> 0 wrap crosses
    configure(16, 10, 1);
    ramp = 0;
    step(0, 0, 1, 0);
    run(0, 0, -1, -1, 2000);
    read_idx(16);
    check("fall_trig_sample", {24'b0, rd_data}, 0);
    compare_buffer("fall");

    // pretrig 0, forced trigger (pulse on an idle cycle, lands on next valid)
    configure(0, 255, 0);
    ramp = 40;
    step(0, 0, 1, 0);
    run(0, 0, 5, -1, 100);
    step(0, 0, 0, 1);
    forced = ramp;
    step(1, ramp, 0, 0);
    ramp++;
    run(0, 0, -1, -1, 2000);
    read_idx(0);
    check("force_idx0", {24'b0, rd_data}, forced);
    compare_buffer("force");

    // Toggling valid: same contents as gap-free ramp run
    configure(16, 128, 0);
    ramp = 0;
    step(0, 0, 1, 0);
    run(0, 1, -1, -1, 4000);
    table_reads("toggle");
    compare_buffer("toggle");

    // Reset mid-POST, with arm held too, then a clean capture
    configure(16, 128, 0);
    ramp = 0;
    step(0, 0, 1, 0);
    run(0, 0, -1, 10, 2000);
    check("midpost_busy", {31'b0, busy}, 1);
    do_rst(1);
    step(0, 0, 0, 0);
    ramp = 0;
    step(0, 0, 1, 0);
    run(0, 0, -1, -1, 2000);
    table_reads("after_rst");

    // Arm in the same cycle as the trigger sample
    configure(16, 128, 0);
    ramp = 0;
    step(0, 0, 1, 0);
    run(0, 0, 128, -1, 2000);
    step(1, 128, 1, 0);
    check("rearm_busy", {31'b0, busy}, 1);
    check("rearm_done", {31'b0, done}, 0);
    ramp = 129;
    run(0, 0, -1, -1, 2000);
    compare_buffer("rearm");

    // Randomized captures
    for (int r = 0; r < 5; r++) begin
      configure($urandom_range(0, 255), $urandom_range(1, 254), $urandom_range(0, 1));
      step(0, 0, 1, 0);
      run(1, 2, -1, -1, 8000);
      compare_buffer("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
